branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_if.sv | 51 +++++
 rtl/branch_resolve.sv | 153 +++++++++++++++
 tb/tb_branch_resolve.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_if
// Groups the upstream op handshake, the downstream result handshake and the
// flush/statistics outputs of the branch resolution block.
//   master : the environment side. It drives the op and out_ready, and
//            observes the results.
//   slave  : the branch_resolve block itself.
// Signals:
//   in_valid/in_ready        upstream op handshake
//   funct3, zero/neg/negu    branch condition code and comparator flags
//   pred_taken               front-end prediction for the op
//   pc, imm                  branch PC and sign-extended offset
//   out_valid/out_ready      downstream result handshake
//   taken/mispredict/illegal resolved outcome
//   redirect_pc              correct next PC
//   flush                    squash younger front-end instructions
//   mispredict_cnt           saturating misprediction count
// ---------------------------------------------------------------------------
interface branch_resolve_if #(
  parameter int BUS_WIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           funct3;
  logic                 zero;
  logic                 neg;
  logic                 negu;
  logic                 pred_taken;
  logic [BUS_WIDTH-1:0] pc;
  logic [BUS_WIDTH-1:0] imm;
  logic                 out_valid;
  logic                 out_ready;
  logic                 taken;
  logic                 mispredict;
  logic                 illegal;
  logic [BUS_WIDTH-1:0] redirect_pc;
  logic                 flush;
  logic [31:0]          mispredict_cnt;

  modport master (
    output in_valid, funct3, zero, neg, negu, pred_taken, pc, imm, out_ready,
    input  in_ready, out_valid, taken, mispredict, illegal, redirect_pc,
           flush, mispredict_cnt
  );

  modport slave (
    input  in_valid, funct3, zero, neg, negu, pred_taken, pc, imm, out_ready,
    output in_ready, out_valid, taken, mispredict, illegal, redirect_pc,
           flush, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Resolves a conditional branch from comparator flags. The block computes the
// correct next PC and compares the outcome against the front-end prediction.
// A result is registered one cycle after acceptance. It is held until the
// downstream side consumes it. A consumed misprediction opens a flush window
// of FLUSH_CYCLES cycles, during which no new op is accepted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    branch_resolve_if.slave (op in, result out, flush, statistics)
// Parameters:
//   BUS_WIDTH     width of PC, offset and redirect address
//   FLUSH_CYCLES  flush window length, 1..15
// ---------------------------------------------------------------------------
module branch_resolve #(
  parameter int BUS_WIDTH    = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolve_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t               state_q;
  logic                 out_valid_q;
  logic                 flush_q;
  logic                 taken_q;
  logic                 mispredict_q;
  logic                 illegal_q;
  logic [BUS_WIDTH-1:0] redirect_pc_q;
  logic [31:0]          mispredict_cnt_q;
  logic [3:0]           flush_cnt_q;

  logic                 taken_d;
  logic                 illegal_d;
  logic                 mispredict_d;
  logic [BUS_WIDTH-1:0] redirect_pc_d;
  logic [BUS_WIDTH-1:0] target;
  logic [BUS_WIDTH-1:0] fall_through;
  logic                 in_ready;
  logic                 accept;

  // Resolve the incoming op combinationally. The result is captured only
  // when the op is accepted.
  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (bus.funct3)
      3'b000:  taken_d = bus.zero;
      3'b001:  taken_d = ~bus.zero;
      3'b100:  taken_d = bus.neg;
      3'b101:  taken_d = ~bus.neg;
      3'b110:  taken_d = bus.negu;
      3'b111:  taken_d = ~bus.negu;
      default: illegal_d = 1'b1;
    endcase
    // An unsupported condition is never reported as a misprediction.
    mispredict_d  = ~illegal_d & (taken_d ^ bus.pred_taken);
    // Both additions wrap modulo 2^BUS_WIDTH; the carry is dropped.
    target        = bus.pc + bus.imm;
    fall_through  = bus.pc + BUS_WIDTH'(4);
    redirect_pc_d = taken_d ? target : fall_through;
  end

  // A held misprediction must leave through FLUSH, so it blocks a
  // back-to-back accept even when downstream is ready.
  assign in_ready = (state_q == IDLE) |
                    ((state_q == HOLD) & bus.out_ready & ~mispredict_q);
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      out_valid_q      <= 1'b0;
      flush_q          <= 1'b0;
      taken_q          <= 1'b0;
      mispredict_q     <= 1'b0;
      illegal_q        <= 1'b0;
      redirect_pc_q    <= '0;
      mispredict_cnt_q <= '0;
      flush_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            taken_q       <= taken_d;
            mispredict_q  <= mispredict_d;
            illegal_q     <= illegal_d;
            redirect_pc_q <= redirect_pc_d;
            out_valid_q   <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (mispredict_q) begin
              state_q     <= FLUSH;
              out_valid_q <= 1'b0;
              flush_q     <= 1'b1;
              flush_cnt_q <= FLUSH_LOAD;
              if (mispredict_cnt_q != 32'hFFFF_FFFF) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
              end
            end else if (accept) begin
              // Back-to-back: replace the consumed result and stay valid.
              taken_q       <= taken_d;
              mispredict_q  <= mispredict_d;
              illegal_q     <= illegal_d;
              redirect_pc_q <= redirect_pc_d;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        FLUSH: begin
          // The counter starts at FLUSH_CYCLES-1. Flush therefore stays high
          // for exactly FLUSH_CYCLES cycles, counting the entry cycle.
          if (flush_cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          flush_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.flush          = flush_q;
  assign bus.taken          = taken_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.illegal        = illegal_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int BW = 64;
  localparam int FC = 2;

  logic clk;
  logic rst_n;

  branch_resolve_if #(.BUS_WIDTH(BW)) bus ();

  branch_resolve #(
    .BUS_WIDTH    (BW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results are tracked per transaction. The queue holds results accepted but
  // not yet consumed, flush_left counts the remaining squash cycles, and
  // mis_cnt counts consumed mispredictions.
  typedef struct {
    logic          t;
    logic          m;
    logic          i;
    logic [BW-1:0] r;
  } res_t;

  res_t        exp_q[$];
  int          flush_left;
  logic [31:0] mis_cnt;
  int          n_cmp;
  int          n_err;
  int          n_txn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t resolve(input logic [2:0] f3, input logic z, input logic n,
                                   input logic nu, input logic pt,
                                   input logic [BW-1:0] p, input logic [BW-1:0] im);
    res_t r;
    r.i = 1'b0;
    case (f3)
      3'd0:    r.t = z;
      3'd1:    r.t = !z;
      3'd4:    r.t = n;
      3'd5:    r.t = !n;
      3'd6:    r.t = nu;
      3'd7:    r.t = !nu;
      default: begin r.t = 1'b0; r.i = 1'b1; end
    endcase
    r.m = r.i ? 1'b0 : (r.t != pt);
    r.r = r.t ? p + im : p + 64'd4;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    flush_left = 0;
    mis_cnt    = '0;
  endtask

  // One clock cycle. The task drives the inputs at the falling edge and
  // checks every output against the model. It then advances the model by
  // what happens at the next rising edge.
  task automatic step(input logic iv, input logic [2:0] f3, input logic z, input logic n,
                      input logic nu, input logic pt, input logic [BW-1:0] p,
                      input logic [BW-1:0] im, input logic ordy);
    logic e_valid;
    logic e_rdy;
    logic acc;
    logic cons;
    res_t head;
    @(negedge clk);
    bus.in_valid   = iv;
    bus.funct3     = f3;
    bus.zero       = z;
    bus.neg        = n;
    bus.negu       = nu;
    bus.pred_taken = pt;
    bus.pc         = p;
    bus.imm        = im;
    bus.out_ready  = ordy;
    #1;
    e_valid = (exp_q.size() != 0);
    e_rdy   = (flush_left == 0) && (!e_valid || (ordy && !exp_q[0].m));
    chk("out_valid", 64'(bus.out_valid), 64'(e_valid));
    chk("flush", 64'(bus.flush), 64'(flush_left > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(e_rdy));
    chk("mis_cnt", 64'(bus.mispredict_cnt), 64'(mis_cnt));
    if (bus.flush && bus.out_valid) chk("flush_and_valid", 64'd1, 64'd0);
    if (e_valid) begin
      head = exp_q[0];
      chk("taken", 64'(bus.taken), 64'(head.t));
      chk("mispredict", 64'(bus.mispredict), 64'(head.m));
      chk("illegal", 64'(bus.illegal), 64'(head.i));
      chk("redirect_pc", bus.redirect_pc, head.r);
    end
    acc  = iv && (flush_left == 0) && (!e_valid || (ordy && !exp_q[0].m));
    cons = e_valid && ordy;
    if (flush_left > 0) flush_left--;
    if (cons) begin
      head = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: taken=%0d mis=%0d ill=%0d redirect=0x%0h", n_txn, head.t, head.m,
               head.i, head.r);
      if (head.m) begin
        flush_left = FC;
        if (mis_cnt != 32'hFFFF_FFFF) mis_cnt = mis_cnt + 32'd1;
      end
    end
    if (acc) exp_q.push_back(resolve(f3, z, n, nu, pt, p, im));
  endtask

  task automatic idle_cycle(input logic ordy);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, ordy);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_txn = 0;
    model_reset();
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.funct3     = 3'd0;
    bus.zero       = 1'b0;
    bus.neg        = 1'b0;
    bus.negu       = 1'b0;
    bus.pred_taken = 1'b0;
    bus.pc         = '0;
    bus.imm        = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_redirect", bus.redirect_pc, 64'd0);
    chk("rst_cnt", 64'(bus.mispredict_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, predicted taken.
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1000, 64'h40, 1'b1);
    idle_cycle(1'b1);
    // BLTU not taken, predicted taken: misprediction with a flush window.
    step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2000, 64'h80, 1'b1);
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h3000, 64'h10, 1'b1);
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h3000, 64'h10, 1'b1);
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h3000, 64'h10, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    // BGE stalled three cycles, then a back-to-back accept.
    step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4000, 64'h20, 1'b0);
    repeat (3) step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5000, 64'h8, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5000, 64'h8, 1'b1);
    idle_cycle(1'b1);
    // Unsupported condition code.
    step(1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 64'h6000, 64'h4, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    // Wrap-around of the target and of the fall-through address.
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b1);
    step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b1);
    idle_cycle(1'b1);

    // Reset during the second flush cycle.
    step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h7000, 64'h10, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    @(negedge clk);
    #1;
    chk("flush2_before_rst", 64'(bus.flush), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_flush", 64'(bus.flush), 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_cnt", 64'(bus.mispredict_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(1'b1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [12:0] off;
      logic [63:0] p;
      off = 13'($urandom);
      p   = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)} :
                                          {32'($urandom), 32'($urandom)};
      step(($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), p, {{51{off[12]}}, off},
           ($urandom_range(0, 9) < 7));
    end
    repeat (FC + 3) idle_cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
